// File: rtl/shift_sequencer_if.sv
// ============================================================================
// Module      : shift_sequencer_if
// Description : Control and feedback bundle between the shift sequencer and
//               the 8-bit load/rotate register, plus its requester.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface shift_sequencer_if;
    logic       start;
    logic       stop;
    logic [7:0] load_data;
    logic [1:0] op;
    logic [3:0] num_steps;
    logic [7:0] reg_q;
    logic [7:0] reg_data;
    logic       reg_loadn;
    logic       reg_rotate;
    logic       reg_asright;
    logic       busy;
    logic       done;
    logic [3:0] steps_left;

    // Requester / register-model side
    modport master (
        output start, stop, load_data, op, num_steps, reg_q,
        input  reg_data, reg_loadn, reg_rotate, reg_asright, busy, done, steps_left
    );

    // Sequencer side
    modport slave (
        input  start, stop, load_data, op, num_steps, reg_q,
        output reg_data, reg_loadn, reg_rotate, reg_asright, busy, done, steps_left
    );
endinterface

`default_nettype wire

// File: rtl/shift_sequencer.sv
// ============================================================================
// Module      : shift_sequencer
// Description : Loads a byte into the downstream load/rotate register, then
//               issues N single-bit shift steps at a divided rate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_sequencer #(
    parameter int STEP_DIV = 4,
    parameter int DIV_W    = 8
) (
    input wire logic          clock,
    input wire logic          reset_value,
    shift_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(STEP_DIV - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_next;
    logic             w_div_term;
    logic [3:0]       r_steps;
    logic [1:0]       r_op;
    logic [3:0]       r_num;
    logic [7:0]       r_data;

    logic       w_step;
    logic [7:0] w_reg_data;
    logic       w_reg_loadn;
    logic       w_reg_rotate;
    logic       w_reg_asright;
    logic       w_busy;
    logic       w_done;

    // A divide-by-one divider degenerates to "every RUN cycle is a step".
    generate
        if (STEP_DIV > 1) begin : g_div_multi
            assign w_div_term = (r_div == c_div_last);
            assign w_div_next = w_div_term ? '0 : r_div + DIV_W'(1);
        end else begin : g_div_single
            assign w_div_term = 1'b1;
            assign w_div_next = '0;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset_value) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_steps <= '0;
            r_op    <= '0;
            r_num   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op   <= bus.op;
                        r_num  <= bus.num_steps;
                        r_data <= bus.load_data;
                    end
                end
                S_LOAD: begin
                    r_div   <= '0;
                    r_steps <= bus.stop ? 4'd0 : r_num;
                end
                S_RUN: begin
                    if (bus.stop) begin
                        r_div   <= '0;
                        r_steps <= '0;
                    end else begin
                        r_div <= w_div_next;
                        if (w_div_term) begin
                            r_steps <= r_steps - 4'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_step        = 1'b0;
        w_reg_data    = bus.reg_q;
        w_reg_loadn   = 1'b0;
        w_reg_rotate  = 1'b0;
        w_reg_asright = 1'b0;
        w_busy        = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_busy     = 1'b1;
                w_reg_data = r_data;
                if (bus.stop) begin
                    w_next_state = S_IDLE;
                end else if (r_num == 4'd0) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                w_step = w_div_term;
                // Step outputs are already committed, so a concurrent stop
                // still lets this step land.
                if (w_step) begin
                    w_reg_loadn   = 1'b1;
                    w_reg_rotate  = (r_op != 2'b00);
                    w_reg_asright = (r_op == 2'b10);
                end
                if (bus.stop) begin
                    w_next_state = S_IDLE;
                end else if (w_step && (r_steps == 4'd1)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign bus.reg_data    = w_reg_data;
    assign bus.reg_loadn   = w_reg_loadn;
    assign bus.reg_rotate  = w_reg_rotate;
    assign bus.reg_asright = w_reg_asright;
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.steps_left  = r_steps;

endmodule

`default_nettype wire
